pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Central hazard controller for the five-stage MIPS pipeline. It compares D-stage source registers against the E and M destination/Tnew pipeline fields to decide stalls. It also sequences the multi-cycle multiply/divide unit with a busy countdown, and holds D-stage HI/LO users until the result is ready. It sits beside the F/D, D/E and E/M pipeline registers: it drives their freeze/bubble controls and the mult/div start strobe, and honours the exception request `Req`.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.
- `CNT_W`, default 4: countdown width; must hold `max(MULT_CYCLES, DIV_CYCLES)`.

Ports (clock `clk`; reset `reset`, synchronous, active-high):
- `clk` in 1: clock.
- `reset` in 1: synchronous active-high reset.
- `Req` in 1: exception/interrupt flush request, same cycle as the pipeline registers see it.
- `D_rs`, `D_rt` in 5: D-stage source register numbers.
- `D_Tuse_rs`, `D_Tuse_rt` in 2: cycles until operand is needed; 3 = not used.
- `D_md_use` in 1: D instruction reads/writes HI/LO or is a mult/div.
- `E_GPRA3`, `M_GPRA3` in 5: destination register of the E and M stages.
- `E_Tnew`, `M_Tnew` in 2: cycles until the E/M result is available.
- `E_md_start` in 1: E-stage instruction is mult/multu/div/divu with `E_ExcCode == 0`.
- `E_md_div` in 1: 1 = div/divu, 0 = mult/multu.
- `stall` out 1: freeze PC and F/D; clear D/E (insert bubble).
- `md_start` out 1: one-cycle strobe telling the mult/div unit to latch operands.
- `md_busy` out 1: countdown nonzero.
- `md_done` out 1: registered one-cycle pulse when the result is ready in HI/LO.

## Operation
- Register hazard, rs: asserted when `D_rs != 0` and either of these holds:
  - `D_rs == E_GPRA3` and `E_Tnew > D_Tuse_rs`;
  - `D_rs == M_GPRA3` and `M_Tnew > D_Tuse_rs`.
- Register hazard, rt: identical rule using rt fields.
- Comparisons are unsigned 2-bit. `Tuse = 3` therefore never stalls.
- E match takes precedence for the check; no W check is needed (W Tnew is always 0).
- `md_start = E_md_start & ~md_busy & ~Req`.
- md hazard: `D_md_use & (md_busy | E_md_start)`.
- `stall` = rs hazard | rt hazard | md hazard. It is combinational and is forced 0 while `Req` is 1, because the flush takes priority.
- Sequencer (sub-module) states:
  - IDLE (count 0): on `md_start`, load `DIV_CYCLES` if `E_md_div`, else `MULT_CYCLES`; go to BUSY.
  - BUSY: decrement each cycle. At the edge where count goes 1→0, set `md_done` for one cycle and return to IDLE.
- `E_md_start` while busy is ignored; the stall logic makes this unreachable in legal flow.
- `Req` while BUSY does not abort: the operation was committed in E, and the countdown continues to completion.
- `Req` coincident with `E_md_start` in IDLE: no start, and the count stays 0.
- Reset values: count 0, `md_busy` 0, `md_done` 0. The combinational outputs `stall` and `md_start` read 0 with all-zero inputs.

## Timing
- `stall` and `md_start` are same-cycle combinational.
- `md_start` in cycle t gives:
  - `md_busy` high in cycles t+1 … t+N;
  - `md_done` high in cycle t+N+1, with `md_busy` low in that cycle.
- A D-stage HI/LO user stalls from cycle t through t+N and proceeds in cycle t+N+1.
- A new `md_start` is accepted in the same cycle `md_done` is high.
- Reset mid-operation: the next edge clears count and `md_done`.

## Structure
- Shared package `pipe_pkg` holds:
  - Tnew/Tuse constants (`T_NONE = 3`, `T_0..T_2`);
  - md latencies;
  - the 2-bit Tnew/Tuse typedef.
- One sub-module, `md_seq`, contains the countdown FSM (`md_busy` / `md_done`).
- Hazard comparisons stay in the top module.

## Test plan
- Load-use: `D_rs = 5`, `D_Tuse_rs = 0`, `E_GPRA3 = 5`, `E_Tnew = 2` gives `stall = 1`. With `M_GPRA3 = 5`, `M_Tnew = 1`, and the E match removed, `stall = 1`. With `M_Tnew = 0`, `stall = 0`.
- $0 guard: `D_rt = 0` matching `E_GPRA3 = 0` with `E_Tnew = 2` gives `stall = 0`.
- Mult: `E_md_start = 1`, `E_md_div = 0` at t gives `md_busy` for t+1..t+5 and `md_done` only at t+6. With `D_md_use = 1` held, `stall` is 1 for t..t+5 and 0 at t+6.
- Div with `Req` at t+3 gives busy through t+10 and `md_done` at t+11. `Req` simultaneous with `E_md_start` in IDLE gives `md_start = 0` and busy stays 0.
- Reset asserted at t+2 of a div gives `md_busy = 0` and `md_done = 0` at t+3; a subsequent mult completes normally in 5 cycles.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: Tnew/Tuse encoding,
// mult/div latencies and the sequencer state type.
package pipe_pkg;

    typedef logic [1:0] tnew_t;

    localparam tnew_t T_0    = 2'd0;
    localparam tnew_t T_1    = 2'd1;
    localparam tnew_t T_2    = 2'd2;
    localparam tnew_t T_NONE = 2'd3;  // operand not read, so it can never stall

    localparam int unsigned MD_MULT_CYCLES = 5;
    localparam int unsigned MD_DIV_CYCLES  = 10;
    localparam int unsigned MD_CNT_W       = 4;

    typedef enum logic {
        StIdle,
        StBusy
    } md_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of D/E/M pipeline fields seen by the hazard controller and the
// controls it drives back into the pipeline registers and mult/div unit.
interface pipe_hazard_ctrl_if;
    import pipe_pkg::*;

    logic       Req;
    logic [4:0] D_rs;
    logic [4:0] D_rt;
    tnew_t      D_Tuse_rs;
    tnew_t      D_Tuse_rt;
    logic       D_md_use;
    logic [4:0] E_GPRA3;
    logic [4:0] M_GPRA3;
    tnew_t      E_Tnew;
    tnew_t      M_Tnew;
    logic       E_md_start;
    logic       E_md_div;

    logic       stall;
    logic       md_start;
    logic       md_busy;
    logic       md_done;

    modport master (
        output Req, D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_md_use,
        output E_GPRA3, M_GPRA3, E_Tnew, M_Tnew, E_md_start, E_md_div,
        input  stall, md_start, md_busy, md_done
    );

    modport slave (
        input  Req, D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_md_use,
        input  E_GPRA3, M_GPRA3, E_Tnew, M_Tnew, E_md_start, E_md_div,
        output stall, md_start, md_busy, md_done
    );

endinterface

// File: rtl/pipe_hazard_ctrl_md_seq.sv
// Mult/div busy countdown: loads the operation latency on a start strobe and
// pulses md_done on the cycle the result lands in HI/LO.
module md_seq
    import pipe_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES,
    parameter int unsigned CNT_W       = MD_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start,
    input  logic md_div,
    output logic md_busy,
    output logic md_done
);

    md_state_e        state;
    logic [CNT_W-1:0] count;

    // A start is never refused here once committed; abort only comes from reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= StIdle;
            count   <= '0;
            md_done <= 1'b0;
        end else begin
            md_done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (md_start) begin
                        count <= md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state <= StBusy;
                    end
                end
                StBusy: begin
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        state   <= StIdle;
                        md_done <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign md_busy = (state == StBusy);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller: Tuse/Tnew register stalls, HI/LO user stalls and
// mult/div start sequencing, with exception flush taking priority.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES,
    parameter int unsigned CNT_W       = MD_CNT_W
) (
    input logic               clk,
    input logic               reset,
    pipe_hazard_ctrl_if.slave hz
);

    logic rs_hazard;
    logic rt_hazard;
    logic md_hazard;
    logic md_start;
    logic md_busy;
    logic md_done;

    // The E-stage writer is the youngest producer, so its Tnew decides alone.
    always_comb begin
        rs_hazard = 1'b0;
        if (hz.D_rs != 5'd0) begin
            if (hz.D_rs == hz.E_GPRA3) begin
                rs_hazard = (hz.E_Tnew > hz.D_Tuse_rs);
            end else if (hz.D_rs == hz.M_GPRA3) begin
                rs_hazard = (hz.M_Tnew > hz.D_Tuse_rs);
            end
        end
    end

    always_comb begin
        rt_hazard = 1'b0;
        if (hz.D_rt != 5'd0) begin
            if (hz.D_rt == hz.E_GPRA3) begin
                rt_hazard = (hz.E_Tnew > hz.D_Tuse_rt);
            end else if (hz.D_rt == hz.M_GPRA3) begin
                rt_hazard = (hz.M_Tnew > hz.D_Tuse_rt);
            end
        end
    end

    assign md_hazard = hz.D_md_use & (md_busy | hz.E_md_start);
    assign md_start  = hz.E_md_start & ~md_busy & ~hz.Req;

    assign hz.stall    = ~hz.Req & (rs_hazard | rt_hazard | md_hazard);
    assign hz.md_start = md_start;
    assign hz.md_busy  = md_busy;
    assign hz.md_done  = md_done;

    md_seq #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_seq (
        .clk      (clk),
        .reset    (reset),
        .md_start (md_start),
        .md_div   (hz.E_md_div),
        .md_busy  (md_busy),
        .md_done  (md_done)
    );

endmodule
